// File: rtl/zvc_pkg.sv
// Shared zero-value compression constants, FSM state type and popcount helper.
package zvc_pkg;

  localparam int WORD_WIDTH    = 8;
  localparam int LINE_SIZE     = 128;
  localparam int DIST_WIDTH    = 7;
  localparam int MAX_LIFM_RSIZ = 4;
  localparam int LANES         = 16;

  localparam int NCHUNK  = LINE_SIZE / LANES;
  localparam int MT_W    = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int PTR_W   = $clog2(LINE_SIZE) + 1;
  localparam int IDX_W   = $clog2(LINE_SIZE);
  localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    HOLD
  } zvc_state_e;

  function automatic logic [PTR_W-1:0] popcount(input logic [LINE_SIZE-1:0] v);
    logic [PTR_W-1:0] c;
    c = '0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      c = c + PTR_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/zvc_chunk_expander.sv
// Combinational expansion of one LANES-wide chunk: each set lane pulls the next
// packed word/mapping entry starting at rd_ptr; clear lanes produce zero.
module zvc_chunk_expander
  import zvc_pkg::*;
(
  input  logic [LANES-1:0]                chunk_mask,
  input  logic [PTR_W-1:0]                rd_ptr,
  input  logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_comp,
  input  logic [LINE_SIZE*MT_W-1:0]       mt_comp,
  output logic [LANES*WORD_WIDTH-1:0]     lane_words,
  output logic [LANES*MT_W-1:0]           lane_mt,
  output logic [PTR_W-1:0]                chunk_count
);

  logic [WORD_WIDTH-1:0] comp_words [LINE_SIZE];
  logic [MT_W-1:0]       comp_mt    [LINE_SIZE];

  for (genvar gi = 0; gi < LINE_SIZE; gi++) begin : g_unpack
    assign comp_words[gi] = lifm_comp[gi*WORD_WIDTH +: WORD_WIDTH];
    assign comp_mt[gi]    = mt_comp[gi*MT_W +: MT_W];
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    // Lanes below this one that consume a packed entry ahead of it.
    localparam logic [LANES-1:0] BELOW = LANES'((64'd1 << gi) - 64'd1);
    logic [PTR_W-1:0] src_idx;

    assign src_idx = rd_ptr + popcount(LINE_SIZE'(chunk_mask & BELOW));
    assign lane_words[gi*WORD_WIDTH +: WORD_WIDTH] =
      chunk_mask[gi] ? comp_words[src_idx[IDX_W-1:0]] : '0;
    assign lane_mt[gi*MT_W +: MT_W] =
      chunk_mask[gi] ? comp_mt[src_idx[IDX_W-1:0]] : '0;
  end

  assign chunk_count = popcount(LINE_SIZE'(chunk_mask));

endmodule

// File: rtl/zvc_decompressor.sv
// Zero-value decompressor: rebuilds a full activation/mapping line one chunk per cycle.
// Optional macro ZVC_DECOMP_EARLY_EXIT_EN skips trailing chunks whose mask bits are all zero.
module zvc_decompressor
  import zvc_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_comp,
  input  logic [LINE_SIZE*MT_W-1:0]       mt_comp,
  input  logic [LINE_SIZE-1:0]            nz_mask,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_line,
  output logic [LINE_SIZE*MT_W-1:0]       mt_line,
  output logic                            busy
);

  zvc_state_e                      state_reg;
  logic [CHUNK_W-1:0]              chunk_reg;
  logic [PTR_W-1:0]                rd_ptr_reg;
  logic [LINE_SIZE-1:0]            mask_reg;
  logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_comp_reg;
  logic [LINE_SIZE*MT_W-1:0]       mt_comp_reg;
  logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_line_reg;
  logic [LINE_SIZE*MT_W-1:0]       mt_line_reg;
  logic                            out_valid_reg;
  logic                            in_ready_reg;
  logic                            busy_reg;

  logic [LANES-1:0]            chunk_masks [NCHUNK];
  logic [LANES-1:0]            cur_mask;
  logic [LANES*WORD_WIDTH-1:0] lane_words;
  logic [LANES*MT_W-1:0]       lane_mt;
  logic [PTR_W-1:0]            chunk_count;
  logic                        last_chunk;

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk_mask
    assign chunk_masks[gi] = mask_reg[gi*LANES +: LANES];
  end
  assign cur_mask = chunk_masks[chunk_reg];

`ifdef ZVC_DECOMP_EARLY_EXIT_EN
  // rest_zero[k]: nothing left to place beyond chunk k.
  logic [NCHUNK-1:0] rest_zero;
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_rest
    if (gi == NCHUNK - 1) begin : g_tail
      assign rest_zero[gi] = 1'b1;
    end else begin : g_body
      assign rest_zero[gi] = ~|mask_reg[LINE_SIZE-1:(gi+1)*LANES];
    end
  end
  assign last_chunk = rest_zero[chunk_reg];
`else
  assign last_chunk = (chunk_reg == CHUNK_W'(NCHUNK - 1));
`endif

  zvc_chunk_expander u_expander (
    .chunk_mask  (cur_mask),
    .rd_ptr      (rd_ptr_reg),
    .lifm_comp   (lifm_comp_reg),
    .mt_comp     (mt_comp_reg),
    .lane_words  (lane_words),
    .lane_mt     (lane_mt),
    .chunk_count (chunk_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      chunk_reg     <= '0;
      rd_ptr_reg    <= '0;
      lifm_line_reg <= '0;
      mt_line_reg   <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            mask_reg      <= nz_mask;
            lifm_comp_reg <= lifm_comp;
            mt_comp_reg   <= mt_comp;
            lifm_line_reg <= '0;
            mt_line_reg   <= '0;
            chunk_reg     <= '0;
            rd_ptr_reg    <= '0;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= EXPAND;
          end
        end
        EXPAND: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (chunk_reg == CHUNK_W'(k)) begin
              lifm_line_reg[k*LANES*WORD_WIDTH +: LANES*WORD_WIDTH] <= lane_words;
              mt_line_reg[k*LANES*MT_W +: LANES*MT_W]               <= lane_mt;
            end
          end
          rd_ptr_reg <= rd_ptr_reg + chunk_count;
          chunk_reg  <= chunk_reg + CHUNK_W'(1);
          if (last_chunk) begin
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign lifm_line = lifm_line_reg;
  assign mt_line   = mt_line_reg;

endmodule

// File: tb/tb_zvc_decompressor.sv
// Directed self-checking bench for zvc_decompressor (default or ZVC_DECOMP_EARLY_EXIT_EN build).
module tb_zvc_decompressor;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1023:0] lifm_comp;
  logic [3583:0] mt_comp;
  logic [127:0]  nz_mask;
  logic          out_valid;
  logic          out_ready;
  logic [1023:0] lifm_line;
  logic [3583:0] mt_line;
  logic          busy;

  logic [1023:0] exp_lifm;
  logic [3583:0] exp_mt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zvc_decompressor dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lifm_comp (lifm_comp),
    .mt_comp   (mt_comp),
    .nz_mask   (nz_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lifm_line (lifm_line),
    .mt_line   (mt_line),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [127:0] m);
`ifdef ZVC_DECOMP_EARLY_EXIT_EN
    int last = 0;
    for (int i = 0; i < 128; i++) if (m[i]) last = i / 16;
    return last + 1;
`else
    return 8;
`endif
  endfunction

  // Sequential reference: the n-th set mask bit receives the n-th packed entry.
  task automatic build_expected(input logic [127:0] m, input logic [1023:0] lc,
                                input logic [3583:0] mc);
    int p = 0;
    exp_lifm = '0;
    exp_mt   = '0;
    for (int i = 0; i < 128; i++) begin
      if (m[i]) begin
        exp_lifm[i*8 +: 8]   = lc[p*8 +: 8];
        exp_mt[i*28 +: 28]   = mc[p*28 +: 28];
        p++;
      end
    end
  endtask

  task automatic check_lines(input string name);
    for (int i = 0; i < 128; i++) begin
      check($sformatf("%s lifm[%0d]", name, i), 64'(lifm_line[i*8 +: 8]), 64'(exp_lifm[i*8 +: 8]));
      check($sformatf("%s mt[%0d]", name, i), 64'(mt_line[i*28 +: 28]), 64'(exp_mt[i*28 +: 28]));
    end
  endtask

  task automatic send_and_wait(input string name, input logic [127:0] m,
                               input logic [1023:0] lc, input logic [3583:0] mc);
    int cycles = 0;
    build_expected(m, lc, mc);
    nz_mask   = m;
    lifm_comp = lc;
    mt_comp   = mc;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    nz_mask   = ~m;
    lifm_comp = {32{32'hDEADBEEF}};
    mt_comp   = {112{32'hA5A5C3C3}};
    while (!out_valid && cycles < 50) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    $display("txn %s: out_valid after %0d cycles", name, cycles);
    check({name, " latency"}, 64'(cycles), 64'(exp_latency(m)));
    check({name, " busy"}, 64'(busy), 64'd1);
    check({name, " in_ready"}, 64'(in_ready), 64'd0);
    check_lines(name);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " hs out_valid"}, 64'(out_valid), 64'd0);
    check({name, " hs in_ready"}, 64'(in_ready), 64'd1);
    check({name, " hs busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [127:0]  m;
    logic [1023:0] lc;
    logic [3583:0] mc;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    nz_mask = '0; lifm_comp = '0; mt_comp = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset lifm_line", 64'(|lifm_line), 64'd0);
    check("reset mt_line", 64'(|mt_line), 64'd0);

    // Sparse mask {3,8,15}; entries past the popcount must be ignored.
    m = '0; m[3] = 1'b1; m[8] = 1'b1; m[15] = 1'b1;
    lc = {128{8'hAA}}; lc[0 +: 8] = 8'd13; lc[8 +: 8] = 8'd47; lc[16 +: 8] = 8'd22;
    mc = {128{28'h5A5A5A5}}; mc[0 +: 28] = 28'd1; mc[28 +: 28] = 28'd2; mc[56 +: 28] = 28'd3;
    send_and_wait("sparse", m, lc, mc);
    check("sparse word3", 64'(lifm_line[3*8 +: 8]), 64'd13);
    check("sparse word8", 64'(lifm_line[8*8 +: 8]), 64'd47);
    check("sparse word15", 64'(lifm_line[15*8 +: 8]), 64'd22);
    check("sparse mt15", 64'(mt_line[15*28 +: 28]), 64'd3);
    handshake("sparse");

    // Full mask: straight copy.
    m = '1;
    for (int i = 0; i < 128; i++) begin
      lc[i*8 +: 8]   = 8'(i + 1);
      mc[i*28 +: 28] = 28'(i * 3 + 1);
    end
    send_and_wait("full", m, lc, mc);
    check("full word127", 64'(lifm_line[127*8 +: 8]), 64'd128);
    handshake("full");

    // All-zero mask: output all zero regardless of packed data.
    send_and_wait("zero", '0, {32{32'h12345678}}, {112{32'h87654321}});
    check("zero lifm_line", 64'(|lifm_line), 64'd0);
    handshake("zero");

    // End positions: rd_ptr carries across every chunk.
    m = '0; m[0] = 1'b1; m[127] = 1'b1;
    lc = {128{8'h77}}; lc[0 +: 8] = 8'd5; lc[8 +: 8] = 8'd9;
    mc = {128{28'h1111111}}; mc[0 +: 28] = 28'd40; mc[28 +: 28] = 28'd41;
    send_and_wait("ends", m, lc, mc);
    check("ends word0", 64'(lifm_line[0 +: 8]), 64'd5);
    check("ends word127", 64'(lifm_line[127*8 +: 8]), 64'd9);
    handshake("ends");

    // HOLD with out_ready low: stable output, competing in_valid ignored.
    m = '0; m[3] = 1'b1; m[8] = 1'b1; m[15] = 1'b1;
    lc = '0; lc[0 +: 8] = 8'd100; lc[8 +: 8] = 8'd101; lc[16 +: 8] = 8'd102;
    mc = '0; mc[0 +: 28] = 28'd7; mc[28 +: 28] = 28'd8; mc[56 +: 28] = 28'd9;
    send_and_wait("hold", m, lc, mc);
    for (int c = 0; c < 20; c++) begin
      in_valid  = 1'b1;
      nz_mask   = '1;
      lifm_comp = {128{8'hEE}};
      @(posedge clk);
      #1;
      check($sformatf("hold out_valid c%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("hold in_ready c%0d", c), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    $display("txn hold: held 20 cycles with out_ready low");
    check_lines("hold");
    handshake("hold");

    // Reset during the 4th EXPAND cycle discards the partial line.
    m = '0; m[5] = 1'b1; m[127] = 1'b1;
    nz_mask = m; lifm_comp = {128{8'h3C}}; mt_comp = {112{32'h0F0F0F0F}};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("txn midreset: reset applied in EXPAND");
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset in_ready", 64'(in_ready), 64'd1);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset lifm_line", 64'(|lifm_line), 64'd0);
    check("midreset mt_line", 64'(|mt_line), 64'd0);

    m = '0; m[1] = 1'b1; m[64] = 1'b1; m[100] = 1'b1;
    lc = '0; lc[0 +: 8] = 8'd200; lc[8 +: 8] = 8'd201; lc[16 +: 8] = 8'd202;
    mc = '0; mc[0 +: 28] = 28'd11; mc[28 +: 28] = 28'd12; mc[56 +: 28] = 28'd13;
    send_and_wait("fresh", m, lc, mc);
    handshake("fresh");

    // Single bit in chunk 1: latency 2 with early exit, 8 otherwise.
    m = '0; m[20] = 1'b1;
    lc = {128{8'h99}}; lc[0 +: 8] = 8'd61;
    mc = {128{28'h2222222}}; mc[0 +: 28] = 28'd17;
    send_and_wait("bit20", m, lc, mc);
    check("bit20 word20", 64'(lifm_line[20*8 +: 8]), 64'd61);
    handshake("bit20");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zvc_decompressor.md
Name: zvc_decompressor

Overview:
- Inverse of the zero-value compressor: rebuilds a full activation line (lifm_line) and its mapping-table line (mt_line) from a packed compressed line plus a nonzero bitmask.
- Sits between the compressed-line buffer and the PE array's line loader.
- Expands LANES positions per cycle under an FSM, with valid/ready handshakes on both the input and output sides.

Parameters:
- WORD_WIDTH, 8, bits per activation word
- LINE_SIZE, 128, words per line
- DIST_WIDTH, 7, bits per mapping-table distance entry
- MAX_LIFM_RSIZ, 4, distance entries per word
- LANES, 16, positions expanded per cycle; must divide LINE_SIZE
- Derived NCHUNK = LINE_SIZE/LANES; MT_W = DIST_WIDTH*MAX_LIFM_RSIZ; PTR_W = $clog2(LINE_SIZE)+1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  compressed line offered
- in_ready  out  1  decompressor can accept a line
- lifm_comp  in  LINE_SIZE*WORD_WIDTH  nonzero words packed from index 0 upward
- mt_comp  in  LINE_SIZE*MT_W  mapping entries packed like lifm_comp
- nz_mask  in  LINE_SIZE  bit i=1 means original position i was nonzero
- out_valid  out  1  reconstructed line available
- out_ready  in  1  consumer accepts the line
- lifm_line  out  LINE_SIZE*WORD_WIDTH  reconstructed words, word i at [i*WORD_WIDTH+:WORD_WIDTH]
- mt_line  out  LINE_SIZE*MT_W  reconstructed mapping entries, zero at zero positions
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (sync, active-high, overrides everything):
  - state=IDLE, chunk counter=0, rd_ptr=0.
  - lifm_line=0, mt_line=0, out_valid=0, busy=0, in_ready=1.
- FSM states: IDLE, EXPAND, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register lifm_comp/mt_comp/nz_mask, clear lifm_line/mt_line, chunk=0, rd_ptr=0, go to EXPAND.
  - Inputs may change after the accepting edge.
- EXPAND, one chunk per cycle, chunk k covers positions k*LANES .. k*LANES+LANES-1:
  - Lane j with mask bit set: word = comp[rd_ptr + popcount(mask bits of lanes 0..j-1 of chunk k)], same index into mt_comp.
  - Lane j with mask bit clear: word=0, mt=0.
  - rd_ptr += popcount(chunk mask). PTR_W bits; never wraps for a legal mask.
  - After chunk NCHUNK-1 is written, go to HOLD and set out_valid.
  - in_ready=0 throughout.
- HOLD:
  - out_valid=1; lifm_line/mt_line stable.
  - On out_valid&&out_ready, drop out_valid and go to IDLE. in_ready rises the following cycle; there is no input/output overlap.
- Latency: accepting edge E0, then chunks written at edges E1..E_NCHUNK. out_valid is high after edge E_NCHUNK (8 cycles at defaults). Throughput is one line per NCHUNK+2 cycles with out_ready tied high.
- Boundary conditions:
  - All-zero mask: all NCHUNK cycles still run; output is all zero.
  - Full mask: output equals lifm_comp/mt_comp.
  - Packed entries beyond popcount(nz_mask) are ignored.
  - out_ready held low: HOLD indefinitely, output stable.
  - in_valid while busy: ignored, no capture.
  - Reset mid-EXPAND or in HOLD: immediate return to reset values; the partial line is discarded.

Optional Feature:
- Macro ZVC_DECOMP_EARLY_EXIT_EN.
- Defined: in EXPAND, if all mask bits at positions ≥ (k+1)*LANES are zero after writing chunk k, go directly to HOLD. Remaining positions are already zero from the capture clear. Latency becomes (index of the last chunk with a set bit)+1 cycles, minimum 1 (all-zero mask leaves after chunk 0).
- Undefined: fixed NCHUNK-cycle latency as above.

Decomposition:
- Package zvc_pkg holds:
  - default WORD_WIDTH/LINE_SIZE/DIST_WIDTH/MAX_LIFM_RSIZ/LANES
  - derived NCHUNK, MT_W, PTR_W
  - state enum {IDLE, EXPAND, HOLD}
  - popcount function
- Shared with the compressor.
- One combinational sub-module, zvc_chunk_expander. Inputs: chunk mask, rd_ptr, packed lines. Outputs: LANES words/mt entries and the chunk popcount. The top holds the FSM, registers, and line write-back.

Test Plan:
- mask bits {3,8,15}, lifm_comp words 0..2 = 13,47,22, mt words 0..2 = 1,2,3 -> after 8 cycles: lifm word3=13, word8=47, word15=22, mt word3/8/15 = 1/2/3, all other words 0, out_valid=1.
- mask all ones, lifm_comp word i = i+1 -> lifm_line word i = i+1 for all 128; mask all zero -> lifm_line=0, mt_line=0, out_valid after 8 cycles (1 with EARLY_EXIT_EN).
- Mask bits {0,127}, comp words 5,9 -> word0=5, word127=9. Exercises rd_ptr carry across all chunks; latency is 8 with or without EARLY_EXIT_EN.
- out_ready low for 20 cycles in HOLD -> out_valid and outputs stable, in_ready=0, second in_valid ignored; raise out_ready -> handshake, in_ready=1 the next cycle.
- Assert reset at the 4th EXPAND cycle -> next cycle state IDLE, out_valid=0, lifm_line=0, in_ready=1; a fresh line then decodes correctly.
- EARLY_EXIT_EN, mask bit {20} only -> out_valid after 2 cycles, word20 correct.
